// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing front end: per-bit edge counter, frame bit counter and a
// 3-sample mid-bit majority vote producing one clean bit per bit period.
module uart_rx_edge_bit_sampler #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             ENABLE,
    input  logic             DAT_SAMP_EN,
    input  logic [WIDTH-2:0] PRESCALE,
    output logic [WIDTH-1:0] EDGE_CNT,
    output logic [3:0]       BIT_CNT,
    output logic             SAMPLED_BIT,
    output logic             SAMPLE_VALID,
    output logic             CFG_ERR
);

    logic [WIDTH-2:0] p_q, p_d;
    logic             cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       samp_q, samp_d;
    logic             vote_ok_q, vote_ok_d;
    logic             sampled_q, sampled_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] p_ext;
    logic [WIDTH-1:0] last_edge;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] mid_lo;
    logic [WIDTH-1:0] mid_hi;
    logic             prescale_bad;
    logic             majority;

    assign p_ext     = {1'b0, p_q};
    assign last_edge = p_ext - WIDTH'(1);
    assign mid       = p_ext >> 1;
    assign mid_lo    = mid - WIDTH'(1);
    assign mid_hi    = mid + WIDTH'(1);

    assign prescale_bad = PRESCALE[0] | (PRESCALE < (WIDTH-1)'(8));
    assign majority     = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);

    // Prescale and its legality are only tracked between frames.
    always_comb begin
        p_d       = p_q;
        cfg_err_d = cfg_err_q;
        if (!ENABLE) begin
            p_d       = PRESCALE;
            cfg_err_d = prescale_bad;
        end
    end

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!ENABLE) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (edge_q == last_edge) begin
            edge_d = '0;
            if (bit_q != 4'd15) begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            edge_d = edge_q + WIDTH'(1);
        end
    end

    // vote_ok tracks that every sample edge so far in this bit had DAT_SAMP_EN.
    always_comb begin
        samp_d    = samp_q;
        vote_ok_d = vote_ok_q;
        sampled_d = sampled_q;
        valid_d   = 1'b0;
        if (!ENABLE) begin
            vote_ok_d = 1'b0;
        end else if (edge_q == mid_lo) begin
            if (DAT_SAMP_EN) begin
                samp_d[0] = RX_IN;
            end
            vote_ok_d = DAT_SAMP_EN;
        end else if (edge_q == mid) begin
            if (DAT_SAMP_EN) begin
                samp_d[1] = RX_IN;
            end
            vote_ok_d = vote_ok_q & DAT_SAMP_EN;
        end else if (edge_q == mid_hi) begin
            vote_ok_d = 1'b0;
            if (vote_ok_q && DAT_SAMP_EN) begin
                sampled_d = majority;
                valid_d   = ~cfg_err_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_q       <= (WIDTH-1)'(8);
            cfg_err_q <= 1'b0;
            edge_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            vote_ok_q <= 1'b0;
            sampled_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            p_q       <= p_d;
            cfg_err_q <= cfg_err_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            vote_ok_q <= vote_ok_d;
            sampled_q <= sampled_d;
            valid_q   <= valid_d;
        end
    end

    assign EDGE_CNT     = edge_q;
    assign BIT_CNT      = bit_q;
    assign SAMPLED_BIT  = sampled_q;
    assign SAMPLE_VALID = valid_q;
    assign CFG_ERR      = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Bench for uart_rx_edge_bit_sampler: frames described per cycle, expected
// outputs derived from bit-period arithmetic over the driven line history.
module tb_uart_rx_edge_bit_sampler;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       ENABLE;
    logic       DAT_SAMP_EN;
    logic [5:0] PRESCALE;
    logic [6:0] EDGE_CNT;
    logic [3:0] BIT_CNT;
    logic       SAMPLED_BIT;
    logic       SAMPLE_VALID;
    logic       CFG_ERR;

    int checks = 0;
    int errors = 0;
    int p_lat;
    bit exp_sb;
    bit rx_arr  [0:511];
    bit dse_arr [0:511];
    bit pulse_q [$];

    uart_rx_edge_bit_sampler #(.WIDTH(7)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .ENABLE       (ENABLE),
        .DAT_SAMP_EN  (DAT_SAMP_EN),
        .PRESCALE     (PRESCALE),
        .EDGE_CNT     (EDGE_CNT),
        .BIT_CNT      (BIT_CNT),
        .SAMPLED_BIT  (SAMPLED_BIT),
        .SAMPLE_VALID (SAMPLE_VALID),
        .CFG_ERR      (CFG_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit bad_p(input int p);
        return (p % 2 != 0) || (p < 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Enabled for n_cyc cycles, then one disabled cycle that latches p_next.
    task automatic run_frame(input int n_cyc, input int p_next);
        int p;
        int m;
        int nb;
        int votes;
        bit cfg;
        bit fire;
        p   = p_lat;
        m   = p / 2;
        cfg = bad_p(p);
        for (int n = 0; n <= n_cyc; n++) begin
            ENABLE      = (n < n_cyc);
            RX_IN       = rx_arr[n];
            DAT_SAMP_EN = dse_arr[n];
            PRESCALE    = 6'(p_next);
            nb = n / p;
            if (nb > 15) nb = 15;
            fire = 1'b0;
            if (n >= 3 && (n % p) == m + 2) begin
                fire = dse_arr[n-3] && dse_arr[n-2] && dse_arr[n-1];
            end
            if (fire) begin
                votes  = int'(rx_arr[n-3]) + int'(rx_arr[n-2]) + int'(rx_arr[n-1]);
                exp_sb = (votes >= 2);
            end
            @(negedge CLK);
            check("edge_cnt", EDGE_CNT, n % p);
            check("bit_cnt", BIT_CNT, nb);
            check("sample_valid", SAMPLE_VALID, fire && !cfg);
            check("sampled_bit", SAMPLED_BIT, exp_sb);
            check("cfg_err", CFG_ERR, cfg);
            if (SAMPLE_VALID === 1'b1) pulse_q.push_back(SAMPLED_BIT);
            @(posedge CLK);
            #1;
        end
        p_lat = p_next;
    endtask

    task automatic idle(input int k, input int pres);
        for (int j = 0; j < k; j++) begin
            ENABLE      = 1'b0;
            PRESCALE    = 6'(pres);
            RX_IN       = 1'($urandom);
            DAT_SAMP_EN = 1'($urandom);
            @(negedge CLK);
            check("idle_edge", EDGE_CNT, 0);
            check("idle_bit", BIT_CNT, 0);
            check("idle_valid", SAMPLE_VALID, 0);
            check("idle_sampled", SAMPLED_BIT, exp_sb);
            check("idle_cfg_err", CFG_ERR, (j == 0) ? bad_p(p_lat) : bad_p(pres));
            @(posedge CLK);
            #1;
        end
        p_lat = pres;
    endtask

    initial begin
        bit [7:0]  data;
        bit [10:0] fb;
        int nc;
        int pn;

        RST = 1'b1; ENABLE = 1'b0; DAT_SAMP_EN = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8;
        p_lat = 8;
        exp_sb = 1'b1;
        #2;
        check("rst_edge", EDGE_CNT, 0);
        check("rst_bit", BIT_CNT, 0);
        check("rst_sampled", SAMPLED_BIT, 1);
        check("rst_valid", SAMPLE_VALID, 0);
        check("rst_cfg_err", CFG_ERR, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Illegal prescale 6: error flag one cycle later, no valid pulses.
        idle(2, 6);
        for (int i = 0; i < 512; i++) begin rx_arr[i] = 1'b1; dse_arr[i] = 1'b1; end
        pulse_q.delete();
        run_frame(30, 8);
        check("illegal_pulses", pulse_q.size(), 0);
        idle(2, 9);
        idle(2, 8);

        // Count sequence at P=8 while PRESCALE moves to 16 mid-frame.
        for (int i = 0; i < 512; i++) begin rx_arr[i] = 1'($urandom); dse_arr[i] = 1'b0; end
        run_frame(80, 16);

        // Majority vote at P=16: single glitch then two of three high.
        for (int i = 0; i < 512; i++) begin rx_arr[i] = 1'b0; dse_arr[i] = 1'b1; end
        rx_arr[8]  = 1'b1;
        rx_arr[23] = 1'b1;
        rx_arr[25] = 1'b1;
        pulse_q.delete();
        run_frame(32, 32);
        check("vote_pulses", pulse_q.size(), 2);
        if (pulse_q.size() == 2) begin
            check("vote_glitch", pulse_q[0], 0);
            check("vote_two_high", pulse_q[1], 1);
        end

        // Full 11-bit frame at P=32: start, 0xA5 LSB-first, even parity, stop.
        data = 8'hA5;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[k+1] = data[k];
        fb[9]  = ^data;
        fb[10] = 1'b1;
        for (int i = 0; i < 512; i++) begin
            rx_arr[i]  = (i < 352) ? fb[i/32] : 1'b1;
            dse_arr[i] = 1'b1;
        end
        pulse_q.delete();
        run_frame(352, 8);
        check("frame_pulses", pulse_q.size(), 11);
        if (pulse_q.size() == 11) begin
            for (int k = 0; k < 11; k++) check("frame_bit", pulse_q[k], fb[k]);
        end

        // Bit counter saturation, then abort at edge 4 of bit 3.
        for (int i = 0; i < 512; i++) begin rx_arr[i] = 1'($urandom); dse_arr[i] = 1'b1; end
        run_frame(150, 8);
        for (int i = 0; i < 512; i++) begin rx_arr[i] = 1'($urandom); dse_arr[i] = 1'b1; end
        run_frame(28, 8);

        // Random back-to-back frames with random legal prescale.
        for (int f = 0; f < 8; f++) begin
            nc = $urandom_range(4 * p_lat + 5, p_lat);
            pn = 8 + 2 * $urandom_range(12, 0);
            for (int i = 0; i <= nc; i++) begin
                rx_arr[i]  = 1'($urandom);
                dse_arr[i] = ($urandom_range(9, 0) != 0);
            end
            run_frame(nc, pn);
        end
        idle(3, 8);

        // Async reset between clock edges at edge 5 of bit 1.
        for (int n = 0; n < 13; n++) begin
            ENABLE = 1'b1; RX_IN = 1'b0; DAT_SAMP_EN = 1'b1; PRESCALE = 6'd8;
            @(posedge CLK);
            #1;
        end
        check("pre_rst_edge", EDGE_CNT, 5);
        check("pre_rst_bit", BIT_CNT, 1);
        check("pre_rst_sampled", SAMPLED_BIT, 0);
        #2;
        RST = 1'b1;
        #1;
        check("arst_edge", EDGE_CNT, 0);
        check("arst_bit", BIT_CNT, 0);
        check("arst_sampled", SAMPLED_BIT, 1);
        check("arst_valid", SAMPLE_VALID, 0);
        check("arst_cfg_err", CFG_ERR, 0);
        ENABLE = 1'b0;
        #1;
        RST = 1'b0;
        exp_sb = 1'b1;
        p_lat = 8;
        @(posedge CLK);
        #1;
        idle(2, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_edge_bit_sampler.md
Name: uart_rx_edge_bit_sampler

Overview:
- Timing and sampling front end of the UART receiver; sits directly upstream of the RX control FSM.
- While enabled, counts oversampling clock edges per bit (EDGE_CNT) and received bits per frame (BIT_CNT).
- Takes a 3-sample majority vote of RX_IN around mid-bit and presents one clean SAMPLED_BIT per bit to the start/parity/stop checkers and the deserializer.

Parameters:
WIDTH, 7, edge counter width; PRESCALE is WIDTH-1 bits wide.

Ports:
CLK  input  1  receiver oversampling clock.
RST  input  1  asynchronous, active-high reset.
RX_IN  input  1  serial line, already synchronized to CLK; idle high.
ENABLE  input  1  from FSM; high for the whole frame, START through STOP.
DAT_SAMP_EN  input  1  from FSM; enables mid-bit sampling.
PRESCALE  input  WIDTH-1  oversampling ratio; supported values are even and >=8 (8, 16, 32 nominal).
EDGE_CNT  output  WIDTH  edge position within the current bit, 0..P-1.
BIT_CNT  output  4  bit index within the frame; start bit = 0, data bits = 1..8.
SAMPLED_BIT  output  1  majority-voted value of the current bit.
SAMPLE_VALID  output  1  one-cycle pulse when SAMPLED_BIT updates.
CFG_ERR  output  1  latched PRESCALE value is unsupported.

Behaviour:
- Reset (async, RST=1): EDGE_CNT=0, BIT_CNT=0, SAMPLED_BIT=1, SAMPLE_VALID=0, CFG_ERR=0, sample shift register=0, P_reg=8.
- Prescale latch: while ENABLE=0, P_reg<=PRESCALE every cycle. While ENABLE=1, P_reg holds. A PRESCALE change mid-frame takes effect on the next frame only.
- CFG_ERR: registered; set when the latched value is odd or <8, cleared when a legal value is latched.
  - With CFG_ERR=1, counters still run using P_reg.
  - SAMPLE_VALID is suppressed.
- Edge counter, ENABLE=0: EDGE_CNT<=0, BIT_CNT<=0.
- Edge counter, ENABLE=1:
  - EDGE_CNT==P_reg-1: EDGE_CNT<=0 and BIT_CNT<=BIT_CNT+1, saturating at 15.
  - Otherwise: EDGE_CNT<=EDGE_CNT+1.
- First enabled cycle: EDGE_CNT=0 is visible in the first cycle ENABLE=1. The FSM's flag (EDGE_CNT==P-1) therefore arrives P cycles after ENABLE rises.
- Sampling point: M = P_reg>>1. Sample edges are M-1, M and M+1.
  - On each sample edge with DAT_SAMP_EN=1, RX_IN is captured.
  - On edge M+1: SAMPLED_BIT<=majority(sample@M-1, sample@M, RX_IN) and SAMPLE_VALID<=1 for exactly one cycle.
  - Result timing: visible when EDGE_CNT=M+2, which is <=P-2 for every legal P. The result is therefore stable before the FSM flag cycle.
- SAMPLED_BIT holds between updates. It is never cleared by ENABLE falling.
- DAT_SAMP_EN=0 on any of the three sample edges: that bit's vote is abandoned, no SAMPLE_VALID pulse, SAMPLED_BIT unchanged.
- ENABLE falling mid-bit: counters clear on the next edge and any partial vote is discarded. No SAMPLE_VALID pulse is produced for the aborted bit.
- ENABLE re-asserted in the cycle right after falling (AVALABLE->START back-to-back): counting restarts from EDGE_CNT=0 and BIT_CNT=0, using the newly latched P_reg.
- Widths: EDGE_CNT MSB is always 0 for legal P. Comparisons are zero-extended to WIDTH bits; no signed arithmetic.
- Expected size: about 150-250 lines of RTL, made up of three always blocks (prescale/config, counters, sampler) plus the majority logic.

Test Plan:
1. Count sequence: PRESCALE=8, ENABLE held 1 for 80 cycles -> EDGE_CNT runs 0..7 repeatedly; BIT_CNT increments on each wrap, reading 10 after 80 cycles; no value is skipped.
2. Majority vote: PRESCALE=16, DAT_SAMP_EN=1, RX_IN=0 except a one-cycle 1-glitch at EDGE_CNT=8 -> SAMPLED_BIT=0 and SAMPLE_VALID pulses once when EDGE_CNT=10. Repeat with two 1s at edges 7 and 9 -> SAMPLED_BIT=1.
3. Full 11-bit frame (start, data 0xA5 LSB-first, even parity, stop) at PRESCALE=32 -> exactly 11 SAMPLE_VALID pulses; sampled sequence is 0,1,0,1,0,0,1,0,1,0,1; BIT_CNT reaches 11.
4. Prescale change: PRESCALE switched 8->16 while ENABLE=1 -> wrap stays at 7 until ENABLE drops. Next frame wraps at 15. CFG_ERR stays 0.
5. Abort and illegal config: ENABLE dropped at EDGE_CNT=4 of bit 3 -> next cycle EDGE_CNT=0, BIT_CNT=0, no SAMPLE_VALID. Separately, PRESCALE=6 -> CFG_ERR=1 one cycle later and SAMPLE_VALID never asserts.
6. Async reset: RST pulsed at EDGE_CNT=5 mid-frame, between clock edges -> all outputs return to reset values immediately without waiting for CLK; SAMPLED_BIT=1.
